// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B4 pipelined initiator that turns one
// valid/ready command into one bus cycle and returns a one-cycle
// response pulse with status 00 ok, 01 err, 10 retry exhausted,
// 11 timeout. Retries on wb_rty_i up to MAX_RETRY times.
// Ports: clk_i, rst_i (sync, active high); cmd_* request side;
// rsp_* response side; wb_* Wishbone master port.
// Optional: define WB_MASTER_TIMEOUT_EN to abort a cycle that has
// been held for TIMEOUT_CYCLES cycles without termination.
module wb_cmd_master #(
   parameter int ADDR_WIDTH     = 4,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [3:0]            cmd_sel_i,
   input  logic [31:0]           cmd_dat_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_dat_o,
   output logic [1:0]            rsp_status_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [ADDR_WIDTH-3:0] wb_adr_o,
   output logic [3:0]            wb_sel_o,
   output logic                  wb_we_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i,
   input  logic                  wb_stall_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

   logic [2:0] state;
   logic [7:0] retry_cnt;
   logic       term_en;
   logic       tmo;
   logic       unused_adr;

   assign unused_adr  = ^cmd_adr_i[1:0];
   assign cmd_ready_o = (state == S_IDLE);

   // A termination only counts once the strobe has been taken.
   assign term_en = (state == S_WAIT) ||
                    ((state == S_REQ) && !wb_stall_i);

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tcnt;

   // Restarts on every (re)issue since cyc drops between attempts.
   always_ff @(posedge clk_i) begin
      if (rst_i || !wb_cyc_o)
         tcnt <= '0;
      else
         tcnt <= tcnt + 16'd1;
   end

   assign tmo = wb_cyc_o && (tcnt == TO_LAST);
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         retry_cnt    <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= '0;
         rsp_status_o <= 2'b00;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= '0;
         wb_we_o      <= 1'b0;
         wb_dat_o     <= '0;
      end else begin
         rsp_valid_o <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  wb_adr_o  <= cmd_adr_i[ADDR_WIDTH-1:2];
                  wb_sel_o  <= cmd_sel_i;
                  wb_we_o   <= cmd_we_i;
                  wb_dat_o  <= cmd_dat_i;
                  wb_cyc_o  <= 1'b1;
                  wb_stb_o  <= 1'b1;
                  retry_cnt <= '0;
                  state     <= S_REQ;
               end
            end
            S_REQ, S_WAIT: begin
               if (term_en && wb_err_i) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= 2'b01;
                  rsp_dat_o    <= '0;
                  state        <= S_DONE;
               end else if (term_en && wb_rty_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  if (retry_cnt < MAX_R) begin
                     retry_cnt <= retry_cnt + 8'd1;
                     state     <= S_GAP;
                  end else begin
                     rsp_valid_o  <= 1'b1;
                     rsp_status_o <= 2'b10;
                     rsp_dat_o    <= '0;
                     state        <= S_DONE;
                  end
               end else if (term_en && wb_ack_i) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= 2'b00;
                  rsp_dat_o    <= wb_we_o ? 32'd0 : wb_dat_i;
                  state        <= S_DONE;
               end else if (tmo) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= 2'b11;
                  rsp_dat_o    <= '0;
                  state        <= S_DONE;
               end else if ((state == S_REQ) && !wb_stall_i) begin
                  wb_stb_o <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_GAP: begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               state    <= S_REQ;
            end
            S_DONE: begin
               // Keeps cmd_ready_o low during the response pulse.
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master with a
// response scoreboard queue.
module tb_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [3:0]  cmd_adr, cmd_sel;
   logic [31:0] cmd_dat;
   logic        rsp_valid;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;
   logic        cyc, stb, we;
   logic [1:0]  adr;
   logic [3:0]  sel;
   logic [31:0] dat_o, dat_i;
   logic        ack, err, rty, stall;

   typedef struct {
      logic [1:0]  st;
      logic [31:0] dat;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   rsp_seen = 0;
   int   n0;
   int   n;

   always #5 clk = ~clk;

   wb_cmd_master dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
      .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
      .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat),
      .rsp_status_o(rsp_status),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_adr_o(adr),
      .wb_sel_o(sel), .wb_we_o(we), .wb_dat_o(dat_o),
      .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err),
      .wb_rty_i(rty), .wb_stall_i(stall)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [3:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      cmd_we    = w;
      cmd_adr   = a;
      cmd_sel   = s;
      cmd_dat   = d;
      cmd_valid = 1'b1;
      chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            chk("rsp_spurious", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_status", {30'd0, rsp_status}, {30'd0, e.st});
            chk("rsp_dat", rsp_dat, e.dat);
         end
      end
   end

   initial begin
      rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0;
      cmd_sel = 0; cmd_dat = 0; dat_i = 0;
      ack = 0; err = 0; rty = 0; stall = 0;
      repeat (3) tick();
      chk("rst_cyc", {31'd0, cyc}, 32'd0);
      chk("rst_stb", {31'd0, stb}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_status", {30'd0, rsp_status}, 32'd0);
      chk("rst_rsp_dat", rsp_dat, 32'd0);
      chk("rst_wb_dat", dat_o, 32'd0);
      chk("rst_wb_adr", {30'd0, adr}, 32'd0);
      rst = 1'b0;
      tick();

      // write, no stall, ack next cycle
      exp_q.push_back('{2'b00, 32'd0});
      issue(1'b1, 4'h0, 4'hF, 32'hDEADBEEF);
      chk("t1_cyc", {31'd0, cyc}, 32'd1);
      chk("t1_stb", {31'd0, stb}, 32'd1);
      chk("t1_wb_dat", dat_o, 32'hDEADBEEF);
      chk("t1_we", {31'd0, we}, 32'd1);
      chk("t1_sel", {28'd0, sel}, 32'hF);
      chk("t1_busy", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("t1_wait_stb", {31'd0, stb}, 32'd0);
      chk("t1_wait_cyc", {31'd0, cyc}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t1_rsp_at3", {31'd0, rsp_valid}, 32'd1);
      chk("t1_cyc_drop", {31'd0, cyc}, 32'd0);
      chk("t1_ready_pulse", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("t1_ready_after", {31'd0, cmd_ready}, 32'd1);
      chk("t1_pulse_one", {31'd0, rsp_valid}, 32'd0);

      // read with 5 stall cycles
      exp_q.push_back('{2'b00, 32'h12345678});
      stall = 1'b1;
      issue(1'b0, 4'h4, 4'hF, 32'd0);
      chk("t2_adr", {30'd0, adr}, 32'd1);
      chk("t2_we", {31'd0, we}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_stb_hold", {31'd0, stb}, 32'd1);
         chk("t2_adr_hold", {30'd0, adr}, 32'd1);
      end
      stall = 1'b0;
      tick();
      chk("t2_stb_drop", {31'd0, stb}, 32'd0);
      ack = 1'b1;
      dat_i = 32'h12345678;
      tick();
      ack = 1'b0;
      dat_i = 32'd0;
      chk("t2_rsp", {31'd0, rsp_valid}, 32'd1);
      tick();
      chk("t2_dat_held", rsp_dat, 32'h12345678);

      // retry exhausted: 4 attempts
      exp_q.push_back('{2'b10, 32'd0});
      issue(1'b1, 4'h8, 4'h3, 32'hA5A5A5A5);
      for (int a = 0; a < 4; a++) begin
         chk("t3_cyc_attempt", {31'd0, cyc}, 32'd1);
         tick();
         rty = 1'b1;
         tick();
         rty = 1'b0;
         if (a < 3) begin
            chk("t3_gap_cyc", {31'd0, cyc}, 32'd0);
            chk("t3_gap_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
         end else begin
            chk("t3_exhaust_rsp", {31'd0, rsp_valid}, 32'd1);
         end
      end
      tick();

      // two retries then ack
      exp_q.push_back('{2'b00, 32'd0});
      issue(1'b1, 4'hC, 4'hF, 32'h0BADF00D);
      for (int a = 0; a < 3; a++) begin
         tick();
         if (a < 2) rty = 1'b1;
         else ack = 1'b1;
         tick();
         rty = 1'b0;
         ack = 1'b0;
         if (a < 2) begin
            chk("t3b_gap_cyc", {31'd0, cyc}, 32'd0);
            tick();
         end else begin
            chk("t3b_rsp", {31'd0, rsp_valid}, 32'd1);
         end
      end
      tick();

      // ack and err together: err wins
      exp_q.push_back('{2'b01, 32'd0});
      issue(1'b0, 4'h0, 4'hF, 32'd0);
      tick();
      ack = 1'b1;
      err = 1'b1;
      dat_i = 32'hFFFFFFFF;
      tick();
      ack = 1'b0;
      err = 1'b0;
      dat_i = 32'd0;
      chk("t4_rsp", {31'd0, rsp_valid}, 32'd1);
      tick();

      // terminations with cyc low are ignored
      n0 = rsp_seen;
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      err = 1'b1;
      rty = 1'b1;
      tick();
      err = 1'b0;
      rty = 1'b0;
      tick();
      chk("t4_no_pulse", rsp_seen, n0);
      chk("t4_idle_cyc", {31'd0, cyc}, 32'd0);

`ifdef WB_MASTER_TIMEOUT_EN
      exp_q.push_back('{2'b11, 32'd0});
      issue(1'b0, 4'h4, 4'hF, 32'd0);
      n = 0;
      while (cyc && n < 400) begin
         n++;
         tick();
      end
      chk("t5_cyc_cycles", n, 255);
      chk("t5_rsp", {31'd0, rsp_valid}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t5_late_ack", {31'd0, rsp_valid}, 32'd0);
      tick();
`else
      n0 = rsp_seen;
      issue(1'b0, 4'h4, 4'hF, 32'd0);
      repeat (300) tick();
      chk("t5_cyc_hang", {31'd0, cyc}, 32'd1);
      chk("t5_no_rsp", rsp_seen, n0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      // reset while waiting for termination
      issue(1'b1, 4'h4, 4'hF, 32'h1);
      tick();
      chk("t6_wait_cyc", {31'd0, cyc}, 32'd1);
      chk("t6_wait_stb", {31'd0, stb}, 32'd0);
      n0 = rsp_seen;
      rst = 1'b1;
      tick();
      chk("t6_cyc", {31'd0, cyc}, 32'd0);
      chk("t6_stb", {31'd0, stb}, 32'd0);
      chk("t6_rsp", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      tick();
      chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      chk("t6_no_pulse", rsp_seen, n0);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
